bmsce_nch_mux_seq: RTL and testbench
====================================

// Module: bmsce_nch_mux_seq
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer. Successor to the single-bit 2:1 mux.
//   Adds a handshaked manual select and an auto-scan mode that round-robins channels on a dwell timer.
//   Inserts a one-cycle break-before-make blanking gap on every channel change.
//   Sits between the ui_in/uio_in pin decode and uo_out; one instance per project top.
// PARAMETERS
//   WIDTH  1  bits per channel (>=1)
//   NCH    4  number of input channels (>=1)
//   DWELL  8  RUN cycles per channel in scan mode (>=1)
//   SELW   derived localparam = max(1,$clog2(NCH)); not overridable
// PORTS
//   clk         in   1           clock, rising edge
//   rst_n       in   1           reset, asynchronous, active-low
//   din         in   NCH*WIDTH   channel c at din[c*WIDTH +: WIDTH]
//   mode        in   1           0 = manual select, 1 = auto-scan
//   sel_in      in   SELW        requested channel (manual mode)
//   sel_valid   in   1           sel_in request valid
//   sel_ready   out  1           request accepted when sel_valid & sel_ready at a rising edge
//   sel_err     out  1           1-cycle pulse: accepted request had sel_in >= NCH
//   dout        out  WIDTH       registered selected data
//   dout_ch     out  SELW        channel index currently driving dout
//   dout_valid  out  1           dout valid (low during blanking)
//   scan_wrap   out  1           1-cycle pulse: scan wrapped NCH-1 -> 0
//   dout_par    out  1           even parity of dout (only with MUX_PARITY_EN)
// BEHAVIOUR
// - One clock: clk. Reset rst_n is asynchronous and active-low.
// - Reset values: dout=0, dout_ch=0, dout_valid=0, sel_ready=0, sel_err=0, scan_wrap=0,
//   dout_par=0, cur_sel=0, dwell_cnt=0, state=RUN. Asserting rst_n mid-SWITCH aborts the switch immediately.
// - States: RUN, SWITCH.
// - RUN, every edge: dout<=din[cur_sel], dout_ch<=cur_sel, dout_valid<=1 (latency 1 cycle).
//   The first edge after reset release gives valid=1.
// - sel_ready: combinational = (state==RUN) & (mode==0) & reset released.
// - Manual accept with sel_in >= NCH: sel_err<=1 for 1 cycle; no switch; dout unaffected.
// - Manual accept with sel_in == cur_sel: no-op; no gap.
// - Manual accept, other legal sel_in: latch target; state<=SWITCH; dout_valid<=0; dout/dout_ch hold.
// - SWITCH, always exactly 1 cycle; at the next edge:
//     cur_sel<=target; dout<=din[target]; dout_ch<=target; dout_valid<=1; state<=RUN.
//   Data from the new channel appears 2 edges after acceptance.
// - Scan mode (mode==1, sampled only in RUN):
//     dwell_cnt increments each RUN edge.
//     At dwell_cnt==DWELL-1: dwell_cnt<=0, target=(cur_sel+1) mod NCH, enter SWITCH.
//     Period per channel = DWELL valid cycles + 1 gap cycle.
//     scan_wrap=1 on the cycle dout_ch becomes 0 via wrap.
// - Mode change takes effect in RUN only. A change during SWITCH lets the switch complete first.
//     scan->manual: dwell_cnt<=0; stay on cur_sel.
//     manual->scan: dwell counts from 0.
// - NCH==1: never switches. scan_wrap never pulses. sel_in=0 is a no-op; any other sel_in raises sel_err.
// - din is sampled only at edges; dout is glitch-free (registered).
// - Arithmetic: dwell_cnt width $clog2(DWELL+1). Channel increment compares against NCH-1; no reliance on power-of-two wrap.
// CONFIGURATION
// - MUX_PARITY_EN defined:
//     dout_par port present; dout_par<=^din[sel] with the same timing as dout.
//     Held during SWITCH; reset value 0.
// - MUX_PARITY_EN undefined: dout_par port and logic absent; all other behaviour identical.
// TESTING (WIDTH=8, NCH=4, DWELL=4 unless stated)
// 1. Reset: rst_n low mid-SWITCH -> all outputs 0 immediately; release with din ch0=0xA5
//    -> dout=0xA5, dout_ch=0, dout_valid=1 after 1st edge.
// 2. Manual switch: ch2=0x3C, sel_in=2, sel_valid for 1 cycle -> sel_ready low 1 cycle;
//    dout_valid low exactly 1 cycle with dout held 0xA5; then dout=0x3C, dout_ch=2.
// 3. Same-select: sel_in=2 while on ch2 -> no gap; dout_valid stays 1.
// 4. Scan: mode=1 -> dout_ch sequence 0,1,2,3,0, each valid 4 cycles with a 1-cycle gap;
//    scan_wrap high exactly 1 cycle when dout_ch returns to 0; sel_ready=0 throughout.
// 5. Illegal select (NCH=3): sel_in=3 accepted -> sel_err 1 cycle; dout_ch and dout_valid unchanged.
// 6. Parity (MUX_PARITY_EN): din ch0=0x07 -> dout_par=1; 0x03 -> dout_par=0.
//    Without the macro, the bench compiles with no dout_par port.

Source files
------------

// File: rtl/bmsce_nch_mux_seq.sv
// bmsce_nch_mux_seq -- N-channel, W-bit registered multiplexer.
//
// Selects one of NCH input channels onto a registered output. The channel is
// chosen either by a valid/ready handshake (mode=0) or by an auto-scan that
// round-robins the channels on a dwell timer (mode=1). Every channel change
// inserts one blanking cycle (dout_valid low, dout/dout_ch held) before the
// new channel is driven.
//
// Optional feature: define MUX_PARITY_EN to add the dout_par output (even
// parity of dout, same timing as dout).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        NCH*WIDTH input bus, channel c at din[c*WIDTH +: WIDTH]
//   mode       0 = manual select, 1 = auto-scan
//   sel_in     requested channel (manual mode)
//   sel_valid  sel_in request valid
//   sel_ready  request accepted when sel_valid & sel_ready at a rising edge
//   sel_err    1-cycle pulse: accepted request was out of range
//   dout       registered selected data
//   dout_ch    channel index currently driving dout
//   dout_valid dout valid (low during blanking)
//   scan_wrap  1-cycle pulse: scan wrapped from the last channel to 0
//   dout_par   even parity of dout (MUX_PARITY_EN only)
module bmsce_nch_mux_seq #(
  parameter  int WIDTH = 1,
  parameter  int NCH   = 4,
  parameter  int DWELL = 8,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic                 sel_err,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 dout_valid,
  output logic                 scan_wrap
`ifdef MUX_PARITY_EN
  ,
  output logic                 dout_par
`endif
);

  localparam int              DW         = $clog2(DWELL + 1);
  localparam logic [SELW:0]   NCH_X      = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic {RUN, SWITCH} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [SELW-1:0] target_q, target_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0] dout_ch_q, dout_ch_d;
  logic            dout_valid_q, dout_valid_d;
  logic            sel_err_q, sel_err_d;
  logic            scan_wrap_q, scan_wrap_d;
  logic            wrap_pend_q, wrap_pend_d;
  logic [SELW-1:0] next_ch;
  logic            accept;

  function automatic logic [WIDTH-1:0] chan_data(input logic [NCH*WIDTH-1:0] bus,
                                                 input logic [SELW-1:0]      idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx == SELW'(c)) r = bus[c*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign sel_ready = rst_n && (state_q == RUN) && !mode;
  assign accept    = sel_valid && sel_ready;
  // Explicit compare against the last channel so non-power-of-two NCH wraps.
  assign next_ch   = (cur_sel_q == LAST_CH) ? '0 : cur_sel_q + SELW'(1);

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    target_d     = target_q;
    dwell_d      = dwell_q;
    dout_d       = chan_data(din, cur_sel_q);
    dout_ch_d    = cur_sel_q;
    dout_valid_d = 1'b1;
    sel_err_d    = 1'b0;
    scan_wrap_d  = 1'b0;
    wrap_pend_d  = wrap_pend_q;
    if (state_q == RUN) begin
      if (!mode) begin
        dwell_d = '0;
        if (accept) begin
          if ({1'b0, sel_in} >= NCH_X) begin
            sel_err_d = 1'b1;
          end else if (sel_in != cur_sel_q) begin
            target_d     = sel_in;
            wrap_pend_d  = 1'b0;
            state_d      = SWITCH;
            dout_valid_d = 1'b0;
            dout_d       = dout_q;
            dout_ch_d    = dout_ch_q;
          end
        end
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        // With a single channel next_ch equals cur_sel, so no switch occurs.
        if (next_ch != cur_sel_q) begin
          target_d     = next_ch;
          wrap_pend_d  = (cur_sel_q == LAST_CH);
          state_d      = SWITCH;
          dout_valid_d = 1'b0;
          dout_d       = dout_q;
          dout_ch_d    = dout_ch_q;
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end else begin
      cur_sel_d   = target_q;
      dout_d      = chan_data(din, target_q);
      dout_ch_d   = target_q;
      scan_wrap_d = wrap_pend_q;
      wrap_pend_d = 1'b0;
      state_d     = RUN;
    end
  end

`ifdef MUX_PARITY_EN
  logic dout_par_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cur_sel_q    <= '0;
      target_q     <= '0;
      dwell_q      <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
      scan_wrap_q  <= 1'b0;
      wrap_pend_q  <= 1'b0;
`ifdef MUX_PARITY_EN
      dout_par_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      target_q     <= target_d;
      dwell_q      <= dwell_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      sel_err_q    <= sel_err_d;
      scan_wrap_q  <= scan_wrap_d;
      wrap_pend_q  <= wrap_pend_d;
`ifdef MUX_PARITY_EN
      dout_par_q   <= ^dout_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign sel_err    = sel_err_q;
  assign scan_wrap  = scan_wrap_q;
`ifdef MUX_PARITY_EN
  assign dout_par   = dout_par_q;
`endif

endmodule

// File: tb/tb_bmsce_nch_mux_seq.sv
// Testbench for bmsce_nch_mux_seq: a WIDTH=8/NCH=4/DWELL=4 instance for the
// main checks and an NCH=3 instance for the out-of-range select. Parity
// checks are compiled in when MUX_PARITY_EN is defined.
module tb_bmsce_nch_mux_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        mode, sel_valid;
  logic [1:0]  sel_in;
  logic        sel_ready, sel_err, dout_valid, scan_wrap;
  logic [7:0]  dout;
  logic [1:0]  dout_ch;

  logic [23:0] din3;
  logic        mode3, sel_valid3;
  logic [1:0]  sel_in3;
  logic        sel_ready3, sel_err3, dout_valid3, scan_wrap3;
  logic [7:0]  dout3;
  logic [1:0]  dout_ch3;
`ifdef MUX_PARITY_EN
  logic        dout_par, dout_par3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bmsce_nch_mux_seq #(.WIDTH(8), .NCH(4), .DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .scan_wrap(scan_wrap)
`ifdef MUX_PARITY_EN
    , .dout_par(dout_par)
`endif
  );

  bmsce_nch_mux_seq #(.WIDTH(8), .NCH(3), .DWELL(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .mode(mode3), .sel_in(sel_in3),
    .sel_valid(sel_valid3), .sel_ready(sel_ready3), .sel_err(sel_err3),
    .dout(dout3), .dout_ch(dout_ch3), .dout_valid(dout_valid3), .scan_wrap(scan_wrap3)
`ifdef MUX_PARITY_EN
    , .dout_par(dout_par3)
`endif
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic       vld;
    logic       rdy;   // sel_ready before the edge
    logic [7:0] dout;  // registered outputs after the edge
    logic [1:0] ch;
    logic       val;
    logic       err;
    logic       wrap;
  } vec_t;

  vec_t vt[8];
  logic [7:0] chv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    chv[0] = 8'hA5; chv[1] = 8'h11; chv[2] = 8'h3C; chv[3] = 8'h7E;
    din  = {chv[3], chv[2], chv[1], chv[0]};
    din3 = {chv[2], chv[1], chv[0]};
    mode = 1'b0; sel_in = '0; sel_valid = 1'b0;
    mode3 = 1'b0; sel_in3 = '0; sel_valid3 = 1'b0;

    //           mode  sel   vld   rdy   dout   ch    val   err   wrap
    vt[0] = '{1'b0, 2'd2, 1'b1, 1'b1, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'h3C, 2'd2, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 2'd2, 1'b1, 1'b1, 8'h3C, 2'd2, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 2'd0, 1'b0, 1'b1, 8'h3C, 2'd2, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 2'd3, 1'b1, 1'b1, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'h7E, 2'd3, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 2'd0, 1'b1, 1'b1, 8'h7E, 2'd3, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'hA5, 2'd0, 1'b1, 1'b0, 1'b0};

    // Reset state, then a reset asserted in the middle of a switch.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ready", sel_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready", sel_ready, 1);
    tick();
    chk("first_dout", dout, 8'hA5);
    chk("first_ch", dout_ch, 0);
    chk("first_valid", dout_valid, 1);
    sel_in = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("pre_abort_valid", dout_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_dout", dout, 0);
    chk("abort_ch", dout_ch, 0);
    chk("abort_valid", dout_valid, 0);
    chk("abort_ready", sel_ready, 0);
    chk("abort_err", sel_err, 0);
    chk("abort_wrap", scan_wrap, 0);
`ifdef MUX_PARITY_EN
    chk("abort_par", dout_par, 0);
`endif
    #1 rst_n = 1'b1;
    tick();
    chk("post_abort_dout", dout, 8'hA5);
    chk("post_abort_ch", dout_ch, 0);
    chk("post_abort_valid", dout_valid, 1);

    // Manual switching, same-select and the blanking gap.
    for (int i = 0; i < 8; i++) begin
      mode = vt[i].mode; sel_in = vt[i].sel; sel_valid = vt[i].vld;
      #1 chk($sformatf("v%0d_ready", i), sel_ready, vt[i].rdy);
      tick();
      chk($sformatf("v%0d_dout", i), dout, vt[i].dout);
      chk($sformatf("v%0d_ch", i), dout_ch, vt[i].ch);
      chk($sformatf("v%0d_valid", i), dout_valid, vt[i].val);
      chk($sformatf("v%0d_err", i), sel_err, vt[i].err);
      chk($sformatf("v%0d_wrap", i), scan_wrap, vt[i].wrap);
    end
    sel_valid = 1'b0;

    // Auto-scan: 4 valid cycles per channel plus one gap, wrap pulse on return to 0.
    mode = 1'b1;
    #1 chk("scan_ready0", sel_ready, 0);
    for (int n = 1; n <= 24; n++) begin
      int ech;
      tick();
      ech = (n % 5 == 4) ? (n / 5) % 4 : ((n + 1) / 5) % 4;
      chk($sformatf("scan%0d_ch", n), dout_ch, ech);
      chk($sformatf("scan%0d_dout", n), dout, chv[ech]);
      chk($sformatf("scan%0d_valid", n), dout_valid, (n % 5 == 4) ? 0 : 1);
      chk($sformatf("scan%0d_wrap", n), scan_wrap, (n == 20) ? 1 : 0);
      chk($sformatf("scan%0d_ready", n), sel_ready, 0);
    end

    // Leaving scan mid-switch: the switch to channel 1 completes, then holds.
    mode = 1'b0;
    #1 chk("exit_ready_sw", sel_ready, 0);
    for (int n = 25; n <= 28; n++) begin
      tick();
      chk($sformatf("hold%0d_ch", n), dout_ch, 1);
      chk($sformatf("hold%0d_dout", n), dout, 8'h11);
      chk($sformatf("hold%0d_valid", n), dout_valid, 1);
      chk($sformatf("hold%0d_ready", n), sel_ready, 1);
    end

    // Out-of-range select on the three-channel instance.
    sel_in3 = 2'd2; sel_valid3 = 1'b1;
    tick();
    sel_valid3 = 1'b0;
    chk("n3_gap_valid", dout_valid3, 0);
    tick();
    chk("n3_ch2", dout_ch3, 2);
    chk("n3_dout2", dout3, 8'h3C);
    sel_in3 = 2'd3; sel_valid3 = 1'b1;
    #1 chk("n3_ready", sel_ready3, 1);
    tick();
    sel_valid3 = 1'b0;
    chk("n3_err", sel_err3, 1);
    chk("n3_err_ch", dout_ch3, 2);
    chk("n3_err_valid", dout_valid3, 1);
    chk("n3_err_dout", dout3, 8'h3C);
    tick();
    chk("n3_err_clear", sel_err3, 0);
    chk("n3_after_ch", dout_ch3, 2);
    chk("n3_wrap", scan_wrap3, 0);

    // Live data on channel 0 and its parity.
    sel_in = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("p_dout_a5", dout, 8'hA5);
`ifdef MUX_PARITY_EN
    chk("p_par_a5", dout_par, 0);
`endif
    din[7:0] = 8'h07;
    tick();
    chk("p_dout_07", dout, 8'h07);
`ifdef MUX_PARITY_EN
    chk("p_par_07", dout_par, 1);
`endif
    din[7:0] = 8'h03;
    tick();
    chk("p_dout_03", dout, 8'h03);
`ifdef MUX_PARITY_EN
    chk("p_par_03", dout_par, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
